// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped, read-only, one-word-per-block instruction cache
//            between the pipelined datapath and the memory controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             r_state;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [TAG_W-1:0]   r_miss_tag;
    logic [IDX_W-1:0]   r_miss_idx;
    logic               r_iren;

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_idx;
    logic               w_match;
    logic               w_hit;
    logic               w_fill;
    logic               w_unused_bits;

    assign w_tag         = imemaddr[31:IDX_W+2];
    assign w_idx         = imemaddr[IDX_W+1:2];
    assign w_unused_bits = &{1'b0, imemaddr[1:0]};

    assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Lookups are suppressed while a fill is outstanding so a redirected
    // address cannot hit on a frame that is about to be overwritten.
    assign w_hit   = imemREN && w_match && (r_state == IDLE);
    assign w_fill  = (r_state == FETCH) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;
    assign iREN     = r_iren;
    assign iaddr    = {r_miss_tag, r_miss_idx, 2'b00};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            r_iren     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_match) begin
                        r_miss_tag <= w_tag;
                        r_miss_idx <= w_idx;
                        r_iren     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_valid[r_miss_idx] <= 1'b1;
                        r_iren              <= 1'b0;
                        r_state             <= IDLE;
                    end
                end
                default: begin
                    r_iren  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_data[r_miss_idx] <= iload;
        end
    end

endmodule

`default_nettype wire
